// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped I/O and interrupt controller.
//   - BUS_W       : data/address bus width
//   - IO_*        : register-select codes presented on io_addr
//   - IRQ_TIMER   : interrupt source index owned by the down-timer
//   - lowest_set  : index of the lowest set bit (0 when none is set)
package io_pkg;

    localparam int BUS_W = 16;

    localparam logic [3:0] IO_EXT0    = 4'd0;
    localparam logic [3:0] IO_EXT1    = 4'd1;
    localparam logic [3:0] IO_EXT2    = 4'd2;
    localparam logic [3:0] IO_EXT3    = 4'd3;
    localparam logic [3:0] IO_EXT4    = 4'd4;
    localparam logic [3:0] IO_EXT5    = 4'd5;
    localparam logic [3:0] IO_EXT6    = 4'd6;
    localparam logic [3:0] IO_EXT7    = 4'd7;
    localparam logic [3:0] IO_IEN     = 4'd8;
    localparam logic [3:0] IO_IPEND   = 4'd9;
    localparam logic [3:0] IO_VBASE   = 4'd10;
    localparam logic [3:0] IO_TRELOAD = 4'd11;
    localparam logic [3:0] IO_TCOUNT  = 4'd12;

    localparam logic [2:0] IRQ_TIMER  = 3'd7;

    // Lowest-index set bit; scanning downward lets the lowest index win.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_controller_chk.sv
// io_controller_chk: simulation-time protocol checks on the control strobes.
// Ports:
//   clk, rst          : clock and reset (checks idle during reset)
//   io_store_retaddr  : interrupt accept strobe
//   has_cand          : some enabled interrupt is pending
//   io_push, io_push_retaddr, io_push_ints : mutually exclusive d_bus drivers
module io_controller_chk (
    input logic clk,
    input logic rst,
    input logic io_store_retaddr,
    input logic has_cand,
    input logic io_push,
    input logic io_push_retaddr,
    input logic io_push_ints
);

    // An accept with nothing to accept is a control-unit bug.
    a_accept_has_cand: assert property (@(posedge clk) disable iff (rst)
        io_store_retaddr |-> has_cand);

    // At most one block may own d_bus per cycle.
    a_single_push: assert property (@(posedge clk) disable iff (rst)
        $onehot0({io_push, io_push_retaddr, io_push_ints}));

endmodule

// File: rtl/io_timer.sv
// io_timer: reloadable down-counter that pulses expire once every `reload`
// cycles; a reload value of zero parks the count at zero.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   reload   : period; while load is high this is the newly written value
//   load     : restart the count from reload this cycle (beats expiry)
//   count    : current count
//   expire   : one-cycle pulse in the cycle the count is 1
module io_timer
    import io_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] reload,
    input  logic             load,
    output logic [BUS_W-1:0] count,
    output logic             expire
);

    logic [BUS_W-1:0] count_r;

    assign count  = count_r;
    assign expire = !load && (reload != 16'h0000) && (count_r == 16'h0001);

    // Count register: load, park at zero, wrap to reload, or decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 16'h0000;
        end else if (load) begin
            count_r <= reload;
        end else if (reload == 16'h0000) begin
            count_r <= 16'h0000;
        end else if (count_r <= 16'h0001) begin
            count_r <= reload;
        end else begin
            count_r <= count_r - 16'h0001;
        end
    end

endmodule

// File: rtl/io_controller.sv
// io_controller: memory-mapped I/O ports plus an 8-source edge-triggered
// interrupt controller on the shared CPU data bus.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   io_addr/_read     : register select and its qualifier
//   io_read, io_push  : load holding register / drive it onto d_bus
//   io_write          : capture d_bus into the selected register
//   io_store_retaddr  : accept interrupt, capture PC from d_bus
//   io_push_retaddr   : drive retaddr onto d_bus, clear act_valid
//   io_push_ints      : drive interrupt status onto d_bus
//   io_push_int_addr  : drive vec_base + winner onto addr_bus
//   io_interrupt      : registered "enabled interrupt pending"
//   d_bus, addr_bus   : shared tri-state buses
//   ext_in, ext_out   : eight 16-bit external ports
//   irq_in            : asynchronous interrupt sources 0-6 (7 is the timer)
module io_controller
    import io_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = 16'h0010,
    parameter int          N_EXT    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  io_addr,
    input  logic                        io_addr_read,
    input  logic                        io_read,
    input  logic                        io_push,
    input  logic                        io_write,
    input  logic                        io_store_retaddr,
    input  logic                        io_push_retaddr,
    input  logic                        io_push_ints,
    input  logic                        io_push_int_addr,
    output logic                        io_interrupt,
    inout  wire  [BUS_W-1:0]            d_bus,
    inout  wire  [BUS_W-1:0]            addr_bus,
    input  logic [N_EXT-1:0][BUS_W-1:0] ext_in,
    output logic [N_EXT-1:0][BUS_W-1:0] ext_out,
    input  logic [6:0]                  irq_in
);

    logic [N_EXT-1:0][BUS_W-1:0] ext_out_r;
    logic [7:0]       enable_r;
    logic [7:0]       pending_r;
    logic [BUS_W-1:0] vec_base_r;
    logic [BUS_W-1:0] reload_r;
    logic [BUS_W-1:0] retaddr_r;
    logic [BUS_W-1:0] hold_r;
    logic [2:0]       act_idx_r;
    logic             act_valid_r;
    logic             io_interrupt_r;
    logic [6:0]       sync1_r;
    logic [6:0]       sync2_r;
    logic [6:0]       sync3_r;

    logic             wr_s;
    logic             rd_s;
    logic [7:0]       cand_s;
    logic             has_cand_s;
    logic [2:0]       winner_s;
    logic             accept_s;
    logic             load_s;
    logic [BUS_W-1:0] reload_val_s;
    logic [BUS_W-1:0] count_s;
    logic             expire_s;
    logic [7:0]       set_s;
    logic [7:0]       clr_s;
    logic [BUS_W-1:0] rd_val_s;
    logic [BUS_W-1:0] d_out_s;
    logic             d_en_s;

    assign wr_s         = io_write & io_addr_read;
    assign rd_s         = io_read & io_addr_read;
    assign cand_s       = pending_r & enable_r;
    assign has_cand_s   = |cand_s;
    assign winner_s     = lowest_set(cand_s);
    assign accept_s     = io_store_retaddr & has_cand_s;
    assign load_s       = wr_s && (io_addr == IO_TRELOAD);
    // While loading, the timer must see the incoming value, not the old one.
    assign reload_val_s = load_s ? d_bus : reload_r;

    assign ext_out      = ext_out_r;
    assign io_interrupt = io_interrupt_r;

    io_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .reload (reload_val_s),
        .load   (load_s),
        .count  (count_s),
        .expire (expire_s)
    );

    io_controller_chk u_chk (
        .clk              (clk),
        .rst              (rst),
        .io_store_retaddr (io_store_retaddr),
        .has_cand         (has_cand_s),
        .io_push          (io_push),
        .io_push_retaddr  (io_push_retaddr),
        .io_push_ints     (io_push_ints)
    );

    // Pending set/clear terms; sets are OR-ed in last so they win collisions.
    always_comb begin
        set_s            = {1'b0, sync2_r & ~sync3_r};
        set_s[IRQ_TIMER] = expire_s;
        clr_s            = 8'h00;
        if (wr_s && (io_addr == IO_IPEND)) begin
            clr_s = d_bus[7:0];
        end else begin
            clr_s = 8'h00;
        end
        if (accept_s) begin
            clr_s = clr_s | (8'h01 << winner_s);
        end else begin
            clr_s = clr_s;
        end
    end

    // Register read mux feeding the holding register.
    always_comb begin
        rd_val_s = 16'h0000;
        case (io_addr)
            IO_EXT0, IO_EXT1, IO_EXT2, IO_EXT3,
            IO_EXT4, IO_EXT5, IO_EXT6, IO_EXT7: rd_val_s = ext_in[io_addr[2:0]];
            IO_IEN:     rd_val_s = {8'h00, enable_r};
            IO_IPEND:   rd_val_s = {8'h00, pending_r};
            IO_VBASE:   rd_val_s = vec_base_r;
            IO_TRELOAD: rd_val_s = reload_r;
            IO_TCOUNT:  rd_val_s = count_s;
            default:    rd_val_s = 16'h0000;
        endcase
    end

    // d_bus driver selection, fixed priority if strobes collide.
    always_comb begin
        d_out_s = 16'h0000;
        d_en_s  = 1'b1;
        if (io_push) begin
            d_out_s = hold_r;
        end else if (io_push_retaddr) begin
            d_out_s = retaddr_r;
        end else if (io_push_ints) begin
            d_out_s = {4'b0000, act_idx_r, act_valid_r, cand_s};
        end else begin
            d_en_s  = 1'b0;
        end
    end

    assign d_bus    = d_en_s ? d_out_s : 16'hzzzz;
    assign addr_bus = io_push_int_addr ? (vec_base_r + {13'b0, winner_s}) : 16'hzzzz;

    // Two-flop synchronizer plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 7'h00;
            sync2_r <= 7'h00;
            sync3_r <= 7'h00;
        end else begin
            sync1_r <= irq_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Interrupt state: pending, accept capture and the registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r      <= 8'h00;
            retaddr_r      <= 16'h0000;
            act_idx_r      <= 3'd0;
            act_valid_r    <= 1'b0;
            io_interrupt_r <= 1'b0;
        end else begin
            pending_r      <= (pending_r & ~clr_s) | set_s;
            io_interrupt_r <= has_cand_s;
            if (accept_s) begin
                retaddr_r   <= d_bus;
                act_idx_r   <= winner_s;
                act_valid_r <= 1'b1;
            end else if (io_push_retaddr) begin
                act_valid_r <= 1'b0;
            end else begin
                act_valid_r <= act_valid_r;
            end
        end
    end

    // Writable registers and the read holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_out_r  <= '0;
            enable_r   <= 8'h00;
            vec_base_r <= VEC_BASE;
            reload_r   <= 16'h0000;
            hold_r     <= 16'h0000;
        end else begin
            if (wr_s) begin
                case (io_addr)
                    IO_EXT0, IO_EXT1, IO_EXT2, IO_EXT3,
                    IO_EXT4, IO_EXT5, IO_EXT6, IO_EXT7: ext_out_r[io_addr[2:0]] <= d_bus;
                    IO_IEN:     enable_r   <= d_bus[7:0];
                    IO_VBASE:   vec_base_r <= d_bus;
                    IO_TRELOAD: reload_r   <= d_bus;
                    default:    enable_r   <= enable_r;
                endcase
            end else begin
                enable_r <= enable_r;
            end
            if (rd_s) begin
                hold_r <= rd_val_s;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with a cycle-level behavioural model.
module tb_io_controller;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        io_addr = 4'd0;
    logic              io_addr_read = 1'b0;
    logic              io_read = 1'b0;
    logic              io_push = 1'b0;
    logic              io_write = 1'b0;
    logic              io_store_retaddr = 1'b0;
    logic              io_push_retaddr = 1'b0;
    logic              io_push_ints = 1'b0;
    logic              io_push_int_addr = 1'b0;
    logic              io_interrupt;
    wire  [15:0]       d_bus;
    wire  [15:0]       addr_bus;
    logic [7:0][15:0]  ext_in = '0;
    logic [7:0][15:0]  ext_out;
    logic [6:0]        irq_in = 7'h00;

    logic              tb_d_en = 1'b0;
    logic [15:0]       tb_d = 16'h0000;
    assign d_bus = tb_d_en ? tb_d : 16'hzzzz;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_on = 1'b0;

    io_controller #(.VEC_BASE(16'h0010), .N_EXT(8)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_addr_read(io_addr_read),
        .io_read(io_read), .io_push(io_push), .io_write(io_write),
        .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
        .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
        .io_interrupt(io_interrupt), .d_bus(d_bus), .addr_bus(addr_bus),
        .ext_in(ext_in), .ext_out(ext_out), .irq_in(irq_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] ext_out_m [8];
    logic [7:0]  enable_m, pending_m;
    logic [15:0] vec_m, reload_m, retaddr_m, hold_m;
    logic [2:0]  act_idx_m;
    logic        act_valid_m, irq_m;
    int          since_m;           // cycles since the last reload write
    logic [6:0]  irq_hist [3];      // irq_in as sampled 1, 2, 3 edges ago

    function automatic int model_winner();
        for (int i = 0; i < 8; i++)
            if (pending_m[i] && enable_m[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] model_count();
        if (reload_m == 16'h0000) return 16'h0000;
        return reload_m - 16'(since_m % int'(reload_m));
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        if (a < 4'd8) return ext_in[a[2:0]];
        if (a == 4'd8) return {8'h00, enable_m};
        if (a == 4'd9) return {8'h00, pending_m};
        if (a == 4'd10) return vec_m;
        if (a == 4'd11) return reload_m;
        if (a == 4'd12) return model_count();
        return 16'h0000;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 8; i++) ext_out_m[i] = 16'h0000;
                enable_m = 8'h00; pending_m = 8'h00; vec_m = 16'h0010;
                reload_m = 16'h0000; retaddr_m = 16'h0000; hold_m = 16'h0000;
                act_idx_m = 3'd0; act_valid_m = 1'b0; irq_m = 1'b0; since_m = 0;
                for (int i = 0; i < 3; i++) irq_hist[i] = 7'h00;
            end else begin
                logic        wr, expire;
                logic [15:0] d, rval;
                logic [7:0]  clr;
                logic [6:0]  edges;
                logic        irq_next;
                int          w;
                wr       = io_write && io_addr_read;
                d        = tb_d_en ? tb_d : 16'h0000;
                rval     = model_read(io_addr);
                w        = model_winner();
                irq_next = (pending_m & enable_m) != 8'h00;
                edges    = irq_hist[1] & ~irq_hist[2];
                irq_hist[2] = irq_hist[1]; irq_hist[1] = irq_hist[0]; irq_hist[0] = irq_in;
                expire = 1'b0;
                if (wr && io_addr == 4'd11) begin
                    reload_m = d; since_m = 0;
                end else if (reload_m != 16'h0000) begin
                    expire = (since_m % int'(reload_m)) == int'(reload_m) - 1;
                    since_m++;
                end
                clr = (wr && io_addr == 4'd9) ? d[7:0] : 8'h00;
                if (io_store_retaddr && w >= 0) begin
                    clr = clr | (8'h01 << w);
                    retaddr_m = d; act_idx_m = 3'(w); act_valid_m = 1'b1;
                end else if (io_push_retaddr) begin
                    act_valid_m = 1'b0;
                end
                pending_m = (pending_m & ~clr) | {expire, edges};
                if (wr && io_addr < 4'd8) ext_out_m[io_addr[2:0]] = d;
                if (wr && io_addr == 4'd8) enable_m = d[7:0];
                if (wr && io_addr == 4'd10) vec_m = d;
                if (io_read && io_addr_read) hold_m = rval;
                irq_m = irq_next;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            int w;
            w = model_winner();
            check("io_interrupt", {15'b0, io_interrupt}, {15'b0, irq_m});
            for (int i = 0; i < 8; i++) check("ext_out", ext_out[i], ext_out_m[i]);
            if (io_push) check("d_bus_push", d_bus, hold_m);
            else if (io_push_retaddr) check("d_bus_retaddr", d_bus, retaddr_m);
            else if (io_push_ints)
                check("d_bus_ints", d_bus, {4'b0000, act_idx_m, act_valid_m, pending_m & enable_m});
            if (io_push_int_addr && w >= 0) check("addr_bus", addr_bus, vec_m + 16'(w));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_strobes();
        io_addr_read = 1'b0; io_read = 1'b0; io_push = 1'b0; io_write = 1'b0;
        io_store_retaddr = 1'b0; io_push_retaddr = 1'b0; io_push_ints = 1'b0;
        io_push_int_addr = 1'b0; tb_d_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] v);
        io_addr = a; io_addr_read = 1'b1; io_write = 1'b1; tb_d_en = 1'b1; tb_d = v;
        tick(); clear_strobes();
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] v);
        io_addr = a; io_addr_read = 1'b1; io_read = 1'b1;
        tick(); clear_strobes();
        io_push = 1'b1; #2; v = d_bus;
        tick(); clear_strobes();
    endtask

    task automatic peek_ints(output logic [15:0] v);
        io_push_ints = 1'b1; #2; v = d_bus; io_push_ints = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        clear_strobes();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state.
        check("rst_io_interrupt", {15'b0, io_interrupt}, 16'h0000);
        check("rst_ext_out0", ext_out[0], 16'h0000);
        rd(4'd10, v); check("rst_vec_base", v, 16'h0010);
        rd(4'd12, v); check("rst_count", v, 16'h0000);

        // Write to port 3.
        wr(4'd3, 16'hA5A5);
        check("wr_ext_out3", ext_out[3], 16'hA5A5);
        check("wr_ext_out2", ext_out[2], 16'h0000);
        check("wr_ext_out4", ext_out[4], 16'h0000);

        // Read port 5.
        ext_in[5] = 16'h1234;
        rd(4'd5, v); check("rd_ext_in5", v, 16'h1234);
        ext_in[6] = 16'h00FF;
        rd(4'd6, v); check("rd_ext_in6", v, 16'h00FF);

        // Priority and accept.
        wr(4'd8, 16'h000C);
        rd(4'd8, v); check("rd_enable", v, 16'h000C);
        irq_in[3:2] = 2'b11;
        tick(); irq_in[3:2] = 2'b00;
        tick(); tick();
        check("irq_lat_early", {15'b0, io_interrupt}, 16'h0000);
        tick();
        check("irq_lat", {15'b0, io_interrupt}, 16'h0001);

        io_store_retaddr = 1'b1; io_push_int_addr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0040;
        #2; check("accept_addr_bus", addr_bus, 16'h0012);
        tick(); clear_strobes();
        peek_ints(v); check("ints_after_accept", v, 16'h0508);
        check("irq_still_high", {15'b0, io_interrupt}, 16'h0001);
        io_push_retaddr = 1'b1; #2; check("push_retaddr", d_bus, 16'h0040);
        tick(); clear_strobes();

        io_store_retaddr = 1'b1; io_push_int_addr = 1'b1; tb_d_en = 1'b1; tb_d = 16'h0077;
        #2; check("accept2_addr_bus", addr_bus, 16'h0013);
        tick(); clear_strobes();
        peek_ints(v); check("ints_after_accept2", v, 16'h0700);
        tick();
        check("irq_falls", {15'b0, io_interrupt}, 16'h0000);
        io_push_retaddr = 1'b1; #2; check("push_retaddr2", d_bus, 16'h0077);
        tick(); clear_strobes();

        // Timer period 5.
        wr(4'd8, 16'h0080);
        wr(4'd11, 16'h0005);
        repeat (4) tick();
        peek_ints(v); check("timer_before_expiry", {15'b0, v[7]}, 16'h0000);
        tick();
        peek_ints(v); check("timer_expiry1", {15'b0, v[7]}, 16'h0001);
        wr(4'd9, 16'h0080);
        repeat (3) tick();
        peek_ints(v); check("timer_cleared", {15'b0, v[7]}, 16'h0000);
        tick();
        peek_ints(v); check("timer_expiry2", {15'b0, v[7]}, 16'h0001);
        rd(4'd12, v);
        rd(4'd11, v); check("rd_reload", v, 16'h0005);
        wr(4'd11, 16'h0000);
        rd(4'd12, v); check("timer_stopped_count", v, 16'h0000);
        wr(4'd9, 16'h00FF);
        repeat (6) tick();
        rd(4'd9, v); check("timer_no_pending", v, 16'h0000);

        // Edge beats W1C on the same bit.
        wr(4'd8, 16'h0002);
        irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
        repeat (4) tick();
        peek_ints(v); check("irq1_pending", {15'b0, v[1]}, 16'h0001);
        irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
        tick();
        wr(4'd9, 16'h0002);
        peek_ints(v); check("collision_set_wins", {15'b0, v[1]}, 16'h0001);
        wr(4'd9, 16'h0002);
        peek_ints(v); check("w1c_clears", {15'b0, v[1]}, 16'h0000);
        repeat (2) tick();

        // Reset between read and push.
        wr(4'd0, 16'hBEEF);
        check("ext_out0_set", ext_out[0], 16'hBEEF);
        wr(4'd10, 16'h0100);
        io_addr = 4'd5; io_addr_read = 1'b1; io_read = 1'b1;
        tick(); clear_strobes();
        rst = 1'b1; tick(); rst = 1'b0;
        io_push = 1'b1; #2; check("push_after_rst", d_bus, 16'h0000);
        tick(); clear_strobes();
        check("rst_ext_out0_again", ext_out[0], 16'h0000);
        check("rst_ext_out3_again", ext_out[3], 16'h0000);
        rd(4'd10, v); check("rst_vec_base_again", v, 16'h0010);
        rd(4'd8, v); check("rst_enable_again", v, 16'h0000);
        rd(4'd13, v); check("rd_unmapped", v, 16'h0000);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
